writeback_regfile: RTL and testbench



---
 rtl/riscv_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 69 ++++++
 rtl/writeback_regfile.sv | 100 ++++++++++
 tb/tb_writeback_regfile.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the writeback / register file slice.
// Optional feature macro used by the slice: WB_BYPASS_EN (writeback bypass).
package riscv_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int PENDING_WIDTH  = 2;

  typedef logic [WORD_SIZE-1:0]      word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [PENDING_WIDTH-1:0]  pending_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one saturating in-flight counter per register,
// plus the source-hazard and destination-full terms used for the decode stall.
// Macro WB_BYPASS_EN: a source whose only pending write sits in the wb latch
// is not treated as a hazard, because the read port forwards that value.
module regfile_scoreboard
  import riscv_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      inc_en,
  input  reg_addr_t inc_addr,
  input  logic      wb_we,
  input  reg_addr_t wb_dest,
  input  reg_addr_t read_addr1,
  input  reg_addr_t read_addr2,
  input  logic      issue_write_enable,
  input  reg_addr_t issue_dest,
  output logic      src1_hazard,
  output logic      src2_hazard,
  output logic      dest_full
);

  pending_t pending      [REG_COUNT];
  pending_t pending_next [REG_COUNT];
  logic     dec_en;
  logic     wb_covers1;
  logic     wb_covers2;

  assign dec_en = wb_we && (wb_dest != '0);

  // Next counter values: simultaneous inc and dec on one register cancel out.
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      pending_next[i] = pending[i];
      if ((inc_en && (inc_addr == reg_addr_t'(i))) &&
          !(dec_en && (wb_dest == reg_addr_t'(i))) &&
          !(&pending[i])) begin
        pending_next[i] = pending[i] + pending_t'(1);
      end else if (!(inc_en && (inc_addr == reg_addr_t'(i))) &&
                   (dec_en && (wb_dest == reg_addr_t'(i))) &&
                   (pending[i] != '0)) begin
        pending_next[i] = pending[i] - pending_t'(1);
      end
    end
    pending_next[0] = '0;
  end

  // Counter state, cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) pending[i] <= pending_next[i];
    end
  end

`ifdef WB_BYPASS_EN
  assign wb_covers1 = wb_we && (wb_dest == read_addr1) && (pending[read_addr1] == pending_t'(1));
  assign wb_covers2 = wb_we && (wb_dest == read_addr2) && (pending[read_addr2] == pending_t'(1));
`else
  assign wb_covers1 = 1'b0;
  assign wb_covers2 = 1'b0;
`endif

  assign src1_hazard = (read_addr1 != '0) && (pending[read_addr1] != '0) && !wb_covers1;
  assign src2_hazard = (read_addr2 != '0) && (pending[read_addr2] != '0) && !wb_covers2;
  assign dest_full   = issue_write_enable && (&pending[issue_dest]);

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: latches the execute result, commits it to the 32-entry
// register file, serves two combinational read ports and drives decode stall.
// Macro WB_BYPASS_EN: read ports forward the value held in the wb latch.
module writeback_regfile
  import riscv_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  word_t       data_in,
  input  reg_addr_t   reg_dest_in,
  input  logic        write_enable_in,
  input  reg_addr_t   read_addr1,
  input  reg_addr_t   read_addr2,
  output word_t       read_data1,
  output word_t       read_data2,
  input  logic        issue_valid,
  input  reg_addr_t   issue_dest,
  input  logic        issue_write_enable,
  output logic        stall,
  output logic [31:0] retire_count
);

  word_t     regs [REG_COUNT];
  word_t     wb_data;
  reg_addr_t wb_dest;
  logic      wb_we;
  logic      src1_hazard;
  logic      src2_hazard;
  logic      dest_full;
  logic      inc_en;

  // Writeback pipeline register fed straight from execute.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_data <= '0;
      wb_dest <= '0;
      wb_we   <= 1'b0;
    end else begin
      wb_data <= data_in;
      wb_dest <= reg_dest_in;
      wb_we   <= write_enable_in;
    end
  end

  // Commit the latched result; x0 is never written.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_we && (wb_dest != '0)) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // Count every committed writeback cycle, x0 targets included; wraps naturally.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      retire_count <= '0;
    end else if (wb_we) begin
      retire_count <= retire_count + 32'd1;
    end
  end

  // Read ports: x0 reads zero, otherwise the architectural value (or the wb latch).
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_addr1 != '0) begin
      read_data1 = regs[read_addr1];
`ifdef WB_BYPASS_EN
      if (wb_we && (wb_dest == read_addr1)) read_data1 = wb_data;
`endif
    end
    if (read_addr2 != '0) begin
      read_data2 = regs[read_addr2];
`ifdef WB_BYPASS_EN
      if (wb_we && (wb_dest == read_addr2)) read_data2 = wb_data;
`endif
    end
  end

  assign stall  = issue_valid && (src1_hazard || src2_hazard || dest_full);
  assign inc_en = issue_valid && !stall && issue_write_enable && (issue_dest != '0);

  regfile_scoreboard u_sb (
    .clock              (clock),
    .reset_n            (reset_n),
    .inc_en             (inc_en),
    .inc_addr           (issue_dest),
    .wb_we              (wb_we),
    .wb_dest            (wb_dest),
    .read_addr1         (read_addr1),
    .read_addr2         (read_addr2),
    .issue_write_enable (issue_write_enable),
    .issue_dest         (issue_dest),
    .src1_hazard        (src1_hazard),
    .src2_hazard        (src2_hazard),
    .dest_full          (dest_full)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile. Stimulus pushes expected output values
// into a queue; a monitor on the falling edge pops and compares them.
module tb_writeback_regfile;
  import riscv_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int SEL_RD1    = 0;
  localparam int SEL_RD2    = 1;
  localparam int SEL_STALL  = 2;
  localparam int SEL_RETIRE = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  word_t       data_in;
  reg_addr_t   reg_dest_in;
  logic        write_enable_in;
  reg_addr_t   read_addr1;
  reg_addr_t   read_addr2;
  word_t       read_data1;
  word_t       read_data2;
  logic        issue_valid;
  reg_addr_t   issue_dest;
  logic        issue_write_enable;
  logic        stall;
  logic [31:0] retire_count;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] want;
  } exp_t;

  exp_t        q [$];
  exp_t        e;
  logic [31:0] act;
  int          assertions = 0;
  int          failures   = 0;

  writeback_regfile dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .data_in            (data_in),
    .reg_dest_in        (reg_dest_in),
    .write_enable_in    (write_enable_in),
    .read_addr1         (read_addr1),
    .read_addr2         (read_addr2),
    .read_data1         (read_data1),
    .read_data2         (read_data2),
    .issue_valid        (issue_valid),
    .issue_dest         (issue_dest),
    .issue_write_enable (issue_write_enable),
    .stall              (stall),
    .retire_count       (retire_count)
  );

  always #5 clock = ~clock;

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clock) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        SEL_RD1:   act = read_data1;
        SEL_RD2:   act = read_data2;
        SEL_STALL: act = {31'd0, stall};
        default:   act = retire_count;
      endcase
      assertions++;
      if (act !== e.want) begin
        failures++;
        $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.want, $time);
      end
    end
    if (reset_n && dut.wb_we && (dut.wb_dest != '0)) begin
      assertions++;
      if (dut.u_sb.pending[dut.wb_dest] == '0) begin
        failures++;
        $display("FAIL zero_decrement: x%0d pending got 0 expected nonzero", dut.wb_dest);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input string name, input int sel, input logic [31:0] want);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.want = want;
    q.push_back(x);
  endtask

  task automatic exec(input reg_addr_t d, input word_t v);
    data_in         = v;
    reg_dest_in     = d;
    write_enable_in = 1'b1;
  endtask

  task automatic exec_off();
    write_enable_in = 1'b0;
    data_in         = '0;
    reg_dest_in     = '0;
  endtask

  task automatic issue(input reg_addr_t d);
    issue_valid        = 1'b1;
    issue_dest         = d;
    issue_write_enable = 1'b1;
  endtask

  task automatic issue_off();
    issue_valid        = 1'b0;
    issue_dest         = '0;
    issue_write_enable = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    exec_off();
    issue_off();
    read_addr1 = '0;
    read_addr2 = '0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state: every register reads zero, no stall, no retirements.
    for (int a = 0; a < REG_COUNT; a++) begin
      read_addr1         = reg_addr_t'(a);
      read_addr2         = reg_addr_t'(31 - a);
      issue_valid        = 1'b1;
      issue_write_enable = 1'b0;
      issue_dest         = reg_addr_t'(a);
      expect_val("reset_rd1", SEL_RD1, 32'd0);
      expect_val("reset_rd2", SEL_RD2, 32'd0);
      expect_val("reset_stall", SEL_STALL, 32'd0);
      if (a == 0) expect_val("reset_retire", SEL_RETIRE, 32'd0);
      tick();
    end
    issue_off();

    // Write 0xDEADBEEF to x5: visible after the second edge (first with bypass).
    issue(5'd5);
    expect_val("x5_issue_stall", SEL_STALL, 32'd0);
    tick();
    issue_off();
    exec(5'd5, 32'hDEADBEEF);
    read_addr1 = 5'd5;
    expect_val("x5_before", SEL_RD1, 32'd0);
    tick();
    exec_off();
    expect_val("x5_wb", SEL_RD1, BYP ? 32'hDEADBEEF : 32'd0);
    expect_val("x5_retire0", SEL_RETIRE, 32'd0);
    tick();
    expect_val("x5_commit", SEL_RD1, 32'hDEADBEEF);
    expect_val("x5_retire1", SEL_RETIRE, 32'd1);
    tick();

    // Write to x0 is dropped but still retires.
    exec(5'd0, 32'h1234);
    read_addr1 = 5'd0;
    read_addr2 = 5'd5;
    expect_val("x0_rd2_x5", SEL_RD2, 32'hDEADBEEF);
    tick();
    exec_off();
    expect_val("x0_wb", SEL_RD1, 32'd0);
    expect_val("x0_retire1", SEL_RETIRE, 32'd1);
    tick();
    expect_val("x0_commit", SEL_RD1, 32'd0);
    expect_val("x0_retire2", SEL_RETIRE, 32'd2);
    tick();

    // RAW hazard on x7 until its writeback commits (one cycle earlier with bypass).
    read_addr1 = '0;
    read_addr2 = '0;
    issue(5'd7);
    expect_val("x7_issue", SEL_STALL, 32'd0);
    tick();
    issue_valid        = 1'b1;
    issue_write_enable = 1'b0;
    issue_dest         = '0;
    read_addr1         = 5'd7;
    exec(5'd7, 32'h777);
    expect_val("x7_stall_pending", SEL_STALL, 32'd1);
    tick();
    exec_off();
    expect_val("x7_stall_wb", SEL_STALL, BYP ? 32'd0 : 32'd1);
    expect_val("x7_rd_wb", SEL_RD1, BYP ? 32'h777 : 32'd0);
    tick();
    expect_val("x7_stall_done", SEL_STALL, 32'd0);
    expect_val("x7_rd_done", SEL_RD1, 32'h777);
    expect_val("x7_retire3", SEL_RETIRE, 32'd3);
    tick();
    issue_off();
    read_addr1 = '0;

    // Three writes in flight to x3 fill its counter; the fourth stalls.
    issue(5'd3);
    for (int k = 0; k < 3; k++) begin
      expect_val("x3_fill", SEL_STALL, 32'd0);
      tick();
    end
    exec(5'd3, 32'h301);
    expect_val("x3_full", SEL_STALL, 32'd1);
    tick();
    exec(5'd3, 32'h302);
    expect_val("x3_full_wb", SEL_STALL, 32'd1);
    tick();
    exec_off();
    expect_val("x3_inc_dec", SEL_STALL, 32'd0);
    tick();
    expect_val("x3_after_inc_dec", SEL_STALL, 32'd0);
    tick();
    exec(5'd3, 32'h303);
    expect_val("x3_full_again", SEL_STALL, 32'd1);
    tick();
    issue_off();
    exec(5'd3, 32'h304);
    read_addr1 = 5'd3;
    expect_val("x3_drain0", SEL_RD1, BYP ? 32'h303 : 32'h302);
    tick();
    exec(5'd3, 32'h305);
    expect_val("x3_drain1", SEL_RD1, BYP ? 32'h304 : 32'h303);
    tick();
    exec_off();
    expect_val("x3_drain2", SEL_RD1, BYP ? 32'h305 : 32'h304);
    tick();
    issue_valid        = 1'b1;
    issue_write_enable = 1'b0;
    issue_dest         = '0;
    read_addr2         = 5'd3;
    expect_val("x3_drained_stall", SEL_STALL, 32'd0);
    expect_val("x3_final", SEL_RD1, 32'h305);
    expect_val("x3_retire8", SEL_RETIRE, 32'd8);
    tick();
    issue_off();

    // Reset with a pending x9 write sitting in the wb latch.
    read_addr1 = '0;
    read_addr2 = '0;
    issue(5'd9);
    expect_val("x9_issue", SEL_STALL, 32'd0);
    tick();
    issue_off();
    exec(5'd9, 32'h999);
    expect_val("x9_retire8", SEL_RETIRE, 32'd8);
    tick();
    exec_off();
    read_addr1 = 5'd9;
    expect_val("x9_wb", SEL_RD1, BYP ? 32'h999 : 32'd0);
    reset_n = 1'b0;
    tick();
    reset_n            = 1'b1;
    issue_valid        = 1'b1;
    issue_write_enable = 1'b1;
    issue_dest         = 5'd9;
    read_addr2         = 5'd5;
    expect_val("rst_x9", SEL_RD1, 32'd0);
    expect_val("rst_x5", SEL_RD2, 32'd0);
    expect_val("rst_stall", SEL_STALL, 32'd0);
    expect_val("rst_retire", SEL_RETIRE, 32'd0);
    tick();
    issue_off();
    tick();

    assertions++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
